// File: rtl/dm_pkg.sv
// Shared definitions for the CPU data-memory responder: MMIO register offsets,
// STATUS register layout and the helper that packs the STATUS byte.
package dm_pkg;

    typedef enum logic [3:0] {
        MMIO_TXDATA = 4'd0,
        MMIO_STATUS = 4'd1,
        MMIO_CYCLES = 4'd2
    } mmio_off_e;

    localparam int MMIO_OFF_W     = 4;
    localparam int STAT_CNT_W     = 3;
    localparam int STAT_EMPTY_BIT = 3;
    localparam int STAT_FULL_BIT  = 4;
    localparam int STAT_OVF_BIT   = 5;
    localparam int OVF_CLR_BIT    = 0;

    // A count equal to the depth wraps to zero in the narrow field; the full bit disambiguates.
    function automatic logic [7:0] status_byte(
        input logic                  ovf,
        input logic                  full,
        input logic                  empty,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [7:0] s;
        s                    = 8'h00;
        s[STAT_OVF_BIT]      = ovf;
        s[STAT_FULL_BIT]     = full;
        s[STAT_EMPTY_BIT]    = empty;
        s[STAT_CNT_W-1:0]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/dm_tx_fifo.sv
// Synchronous byte FIFO between the MMIO TXDATA register and the UART transmitter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dm_tx_fifo
    import dm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_drop
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             valid_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;

    assign valid_s   = (count_r != '0);
    assign full_s    = (count_r == DEPTH_C);
    assign pop_s     = valid_s & pop_ready;
    assign push_ok_s = push & (~full_s | pop_s);

    assign head      = store_r[rd_ptr_r];
    assign valid     = valid_s;
    assign count     = count_r;
    assign push_drop = push & ~push_ok_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-bus responder: async-read data RAM plus a 16-word MMIO window feeding the UART TX FIFO.
// Optional cycle counter at MMIO offset 2 is built when DATA_MEM_RESPONDER_CYCLE_COUNTER_EN is defined.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int               DBITS      = 16,
    parameter int               ADDR       = 11,
    parameter int               RAM_DEPTH  = 1024,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [ADDR-1:0]  MMIO_BASE  = 11'h7F0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR-1:0]   i_addr_dm,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [DBITS-1:0]  i_data_dm,
    output logic [DBITS-1:0]  o_data_dm,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_tx_ovf
);

    localparam int              RAM_AW    = $clog2(RAM_DEPTH);
    localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR-1:0] RAM_LIMIT = ADDR'(RAM_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(FIFO_DEPTH);

    logic [DBITS-1:0]      mem [RAM_DEPTH];
    logic                  ram_sel_s;
    logic                  mmio_sel_s;
    logic [MMIO_OFF_W-1:0] off_s;
    logic                  tx_push_s;
    logic                  ovf_clr_s;
    logic                  push_drop_s;
    logic [CNT_W-1:0]      tx_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [7:0]            status_s;
    logic [DBITS-1:0]      rdata_s;
    logic                  ovf_r;
`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
    logic                  cyc_clr_s;
    logic [DBITS-1:0]      cyc_r;
`endif

    assign ram_sel_s    = (i_addr_dm < RAM_LIMIT);
    assign mmio_sel_s   = (i_addr_dm[ADDR-1:MMIO_OFF_W] == MMIO_BASE[ADDR-1:MMIO_OFF_W]);
    assign off_s        = i_addr_dm[MMIO_OFF_W-1:0];
    assign fifo_full_s  = (tx_count_s == FULL_C);
    assign fifo_empty_s = (tx_count_s == '0);
    assign status_s     = status_byte(ovf_r, fifo_full_s, fifo_empty_s, STAT_CNT_W'(tx_count_s));

    // Decode CPU writes that target MMIO registers.
    always_comb begin
        tx_push_s = 1'b0;
        ovf_clr_s = 1'b0;
`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
        cyc_clr_s = 1'b0;
`endif
        if (i_wr && mmio_sel_s) begin
            case (off_s)
                MMIO_TXDATA: tx_push_s = 1'b1;
                MMIO_STATUS: ovf_clr_s = i_data_dm[OVF_CLR_BIT];
`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
                MMIO_CYCLES: cyc_clr_s = 1'b1;
`endif
                default:     tx_push_s = 1'b0;
            endcase
        end else begin
            tx_push_s = 1'b0;
        end
    end

    // Read mux: RAM is read asynchronously, so a same-cycle write still returns the old word.
    always_comb begin
        rdata_s = '0;
        if (!i_rd) begin
            rdata_s = '0;
        end else if (ram_sel_s) begin
            rdata_s = mem[i_addr_dm[RAM_AW-1:0]];
        end else if (mmio_sel_s) begin
            case (off_s)
                MMIO_STATUS: rdata_s = DBITS'(status_s);
`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
                MMIO_CYCLES: rdata_s = cyc_r;
`endif
                default:     rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    assign o_data_dm = rdata_s;

    // Data RAM write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr && ram_sel_s) begin
            mem[i_addr_dm[RAM_AW-1:0]] <= i_data_dm;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ovf_r <= 1'b0;
        end else if (push_drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_tx_ovf = ovf_r;

`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
    // Free-running counter; a write restarts it so the following cycle reads 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cyc_r <= '0;
        end else if (cyc_clr_s) begin
            cyc_r <= DBITS'(1);
        end else begin
            cyc_r <= cyc_r + DBITS'(1);
        end
    end
`endif

    dm_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .push      (tx_push_s),
        .push_data (i_data_dm[7:0]),
        .pop_ready (i_tx_ready),
        .head      (o_tx_data),
        .valid     (o_tx_valid),
        .count     (tx_count_s),
        .push_drop (push_drop_s)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder with hand-written FIFO corner sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr_dm  (addr),
        .i_rd       (rd),
        .i_wr       (wr),
        .i_data_dm  (wdata),
        .o_data_dm  (rdata),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_tx_ovf   (tx_ovf)
    );

    localparam logic [10:0] A_TX  = 11'h7F0;
    localparam logic [10:0] A_ST  = 11'h7F1;
    localparam logic [10:0] A_CYC = 11'h7F2;

    typedef struct {
        logic [10:0] addr;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic        ready;
        logic [15:0] exp_rdata;
        logic        exp_valid;
        logic [7:0]  exp_tx;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [10:0] a, input logic r, input logic w,
                                input logic [15:0] d, input logic rdy, input logic [15:0] er,
                                input logic ev, input logic [7:0] et, input logic eo);
        vec_t v;
        v.addr = a; v.rd = r; v.wr = w; v.wdata = d; v.ready = rdy;
        v.exp_rdata = er; v.exp_valid = ev; v.exp_tx = et; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one bus cycle, compare mid-cycle, then advance past the rising edge.
    task automatic step(input string nm, input logic [10:0] a, input logic r, input logic w,
                        input logic [15:0] d, input logic rdy, input logic [15:0] er,
                        input logic ev, input logic [7:0] et, input logic eo);
        addr = a; rd = r; wr = w; wdata = d; tx_ready = rdy;
        #4;
        chk({nm, ".rdata"}, rdata, er);
        chk({nm, ".valid"}, {15'd0, tx_valid}, {15'd0, ev});
        if (ev) chk({nm, ".txdata"}, {8'd0, tx_data}, {8'd0, et});
        chk({nm, ".ovf"}, {15'd0, tx_ovf}, {15'd0, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] drain_q [8];
        rst = 1'b0; addr = 11'h000; rd = 1'b0; wr = 1'b0; wdata = 16'h0000; tx_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", {15'd0, tx_valid}, 16'h0000);
        chk("reset.ovf", {15'd0, tx_ovf}, 16'h0000);
        rst = 1'b1;

        //            addr     rd    wr    wdata     rdy   exp_rd    ev    tx     ovf
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h000,1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h005,1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h005,1'b1, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h005,1'b1, 1'b1, 16'h1234, 1'b0, 16'hBEEF, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h005,1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h000,1'b1, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h3FF,1'b0, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h3FF,1'b1, 1'b0, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h400,1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h400,1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h000,1'b1, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h005,1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h7F3,1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h7F3,1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(11'h7EF,1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_TX,   1'b0, 1'b1, 16'h0141, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 8'h41, 1'b0));
        tbl.push_back(mk(A_TX,   1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 8'h41, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_TX,   1'b0, 1'b1, 16'h0142, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_TX,   1'b0, 1'b1, 16'h0243, 1'b0, 16'h0000, 1'b1, 8'h42, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 8'h42, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 8'h42, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 8'h43, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_ST,   1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(A_ST,   1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0));

        foreach (tbl[i]) begin
            step($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata,
                 tbl[i].ready, tbl[i].exp_rdata, tbl[i].exp_valid, tbl[i].exp_tx, tbl[i].exp_ovf);
        end

        // Overflow: nine pushes into an 8-deep FIFO with the transmitter stalled.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("ovf_push%0d", i), A_TX, 1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0,
                 16'h0000, (i > 0), 8'h10, 1'b0);
        end
        step("ovf_status",   A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b1, 8'h10, 1'b1);
        step("ovf_noclr_wr", A_ST, 1'b0, 1'b1, 16'h0FFE, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b1);
        step("ovf_noclr_rd", A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b1, 8'h10, 1'b1);
        step("ovf_clr_wr",   A_ST, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b1);
        step("ovf_clr_rd",   A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1, 8'h10, 1'b0);

        // Full FIFO: push with a simultaneous pop is accepted, no overflow, count stays 8.
        step("full_pushpop", A_TX, 1'b0, 1'b1, 16'h0099, 1'b1, 16'h0000, 1'b1, 8'h10, 1'b0);
        drain_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
        for (int i = 0; i < 8; i++) begin
            step($sformatf("drain%0d", i), A_ST, 1'b1, 1'b0, 16'h0000, 1'b1,
                 (i == 0) ? 16'h0010 : 16'(8 - i), 1'b1, drain_q[i], 1'b0);
        end
        step("drain_done", A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0);

        // Reset while bytes are pending and the overflow flag is set.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("rst_push%0d", i), A_TX, 1'b0, 1'b1, 16'h0020 + 16'(i), 1'b0,
                 16'h0000, (i > 0), 8'h20, 1'b0);
        end
        step("rst_pre", A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b1, 8'h20, 1'b1);
        rst = 1'b0; rd = 1'b0; wr = 1'b0; tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.valid", {15'd0, tx_valid}, 16'h0000);
        chk("midrst.ovf", {15'd0, tx_ovf}, 16'h0000);
        rst = 1'b1;
        step("midrst_status", A_ST, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 8'h00, 1'b0);

`ifdef DATA_MEM_RESPONDER_CYCLE_COUNTER_EN
        step("cyc_wr",  A_CYC, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        step("cyc_rd1", A_CYC, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 8'h00, 1'b0);
        step("cyc_rd2", A_CYC, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 8'h00, 1'b0);
        step("cyc_rd3", A_CYC, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0, 8'h00, 1'b0);
`else
        step("cyc_wr",  A_CYC, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        step("cyc_rd1", A_CYC, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        step("cyc_rd3", A_CYC, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
